// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: operand/tag widths, ALU opcodes and
// the reservation-station entry layout.
package ooo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_PASS = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        alu_op_e           op;
        logic [TAG_W-1:0]  dst_tag;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
    } rs_entry_t;

    // A waiting source captures a broadcast whose tag matches its producer.
    function automatic logic wake_hit(
        input logic             rdy,
        input logic [TAG_W-1:0] tag,
        input logic             bus_valid,
        input logic [TAG_W-1:0] bus_tag
    );
        return !rdy && bus_valid && (tag == bus_tag);
    endfunction

endpackage

// File: rtl/rs_oldest_sel.sv
// Lowest-index priority encoder: slot 0 is the oldest, so the lowest set
// request bit is the oldest ready micro-op.
module rs_oldest_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] index
);

    localparam int IW = $clog2(N);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/issue_sched.sv
// Single-issue reservation station: collapsing age-ordered queue with CDB
// wakeup, oldest-ready select and a lock that holds the offer during stalls.
module issue_sched #(
    parameter int NUM_ENT = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OP_W-1:0]              disp_op,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic                         disp_s1_rdy,
    input  logic [TAG_W-1:0]             disp_s1_tag,
    input  logic [DATA_W-1:0]            disp_s1_val,
    input  logic                         disp_s2_rdy,
    input  logic [TAG_W-1:0]             disp_s2_tag,
    input  logic [DATA_W-1:0]            disp_s2_val,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_val,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_op,
    output logic [TAG_W-1:0]             iss_dst_tag,
    output logic [DATA_W-1:0]            iss_a,
    output logic [DATA_W-1:0]            iss_b,
    output logic [$clog2(NUM_ENT+1)-1:0] occupancy
);

    import ooo_pkg::*;

    localparam int IDX_W = $clog2(NUM_ENT);
    localparam int OCC_W = $clog2(NUM_ENT + 1);

    rs_entry_t          ent_q   [NUM_ENT];
    rs_entry_t          ent_nxt [NUM_ENT];
    rs_entry_t          new_ent;
    logic [OCC_W-1:0]   occ_q;
    logic               lock_q;
    logic [IDX_W-1:0]   lock_idx_q;
    logic [NUM_ENT-1:0] rdy_vec;
    logic               found;
    logic [IDX_W-1:0]   found_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               disp_fire;
    logic               issue_fire;
    logic [OCC_W-1:0]   wr_ptr;

    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            rdy_vec[i] = ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
        end
    end

    rs_oldest_sel #(
        .N(NUM_ENT)
    ) u_sel (
        .req  (rdy_vec),
        .found(found),
        .index(found_idx)
    );

    // While locked, the held index wins even if an older entry became ready.
    assign sel_idx    = lock_q ? lock_idx_q : found_idx;
    assign iss_valid  = lock_q || found;
    assign iss_op     = iss_valid ? ent_q[sel_idx].op      : '0;
    assign iss_dst_tag = iss_valid ? ent_q[sel_idx].dst_tag : '0;
    assign iss_a      = iss_valid ? ent_q[sel_idx].s1_val  : '0;
    assign iss_b      = iss_valid ? ent_q[sel_idx].s2_val  : '0;

    assign occupancy  = occ_q;
    assign disp_ready = (occ_q < OCC_W'(NUM_ENT));
    assign disp_fire  = disp_valid && disp_ready;
    assign issue_fire = iss_valid && iss_ready;
    assign wr_ptr     = occ_q - OCC_W'(issue_fire);

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.op      = alu_op_e'(disp_op);
        new_ent.dst_tag = disp_dst_tag;
        new_ent.s1_rdy  = disp_s1_rdy;
        new_ent.s1_tag  = disp_s1_tag;
        new_ent.s1_val  = disp_s1_val;
        new_ent.s2_rdy  = disp_s2_rdy;
        new_ent.s2_tag  = disp_s2_tag;
        new_ent.s2_val  = disp_s2_val;
        if (wake_hit(disp_s1_rdy, disp_s1_tag, cdb_valid, cdb_tag)) begin
            new_ent.s1_rdy = 1'b1;
            new_ent.s1_val = cdb_val;
        end
        if (wake_hit(disp_s2_rdy, disp_s2_tag, cdb_valid, cdb_tag)) begin
            new_ent.s2_rdy = 1'b1;
            new_ent.s2_val = cdb_val;
        end
    end

    // Wakeup first, then collapse over the issued slot, then append dispatch.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            ent_nxt[i] = ent_q[i];
            if (ent_q[i].valid && wake_hit(ent_q[i].s1_rdy, ent_q[i].s1_tag, cdb_valid, cdb_tag)) begin
                ent_nxt[i].s1_rdy = 1'b1;
                ent_nxt[i].s1_val = cdb_val;
            end
            if (ent_q[i].valid && wake_hit(ent_q[i].s2_rdy, ent_q[i].s2_tag, cdb_valid, cdb_tag)) begin
                ent_nxt[i].s2_rdy = 1'b1;
                ent_nxt[i].s2_val = cdb_val;
            end
        end
        if (issue_fire) begin
            for (int i = 0; i < NUM_ENT - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    ent_nxt[i] = ent_nxt[i+1];
                end
            end
            ent_nxt[NUM_ENT-1] = '0;
        end
        for (int i = 0; i < NUM_ENT; i++) begin
            if (disp_fire && (OCC_W'(i) == wr_ptr)) begin
                ent_nxt[i] = new_ent;
            end
        end
    end

    // Only an issue shifts entries, and an issue also clears the lock, so the
    // held index never needs adjusting while it is live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_q[i] <= '0;
            end
            occ_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_q[i] <= '0;
            end
            occ_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_q[i] <= ent_nxt[i];
            end
            occ_q <= occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
            if (issue_fire) begin
                lock_q <= 1'b0;
            end else if (iss_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
        end
    end

endmodule
